// File: rtl/contador_mod_prog.sv
`default_nettype none
// ============================================================================
// Module      : contador_mod_prog
// Description : Programmable-modulus up/down counter. Counts 0..M-1 with
//               wrap-around in either direction, runtime-loadable modulus,
//               combinational terminal-count / midpoint flags and registered
//               one-cycle wrap (rco) and rejected-modulus (erro) pulses.
//               Optional parallel load on carrega/D is compiled in only when
//               the macro CONTADOR_CARGA_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module contador_mod_prog #(
    parameter int N         = 13,
    parameter int M_DEFAULT = 5000
) (
    input  logic         clock,
    input  logic         zera_s,
    input  logic         conta,
    input  logic         desce,
    input  logic         define_m,
    input  logic [N-1:0] novo_m,
    input  logic         carrega,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q,
    output logic [N-1:0] m_atual,
    output logic         fim,
    output logic         meio,
    output logic         rco,
    output logic         erro
);

    localparam logic [N-1:0] c_ZERO      = '0;
    localparam logic [N-1:0] c_ONE       = N'(1);
    localparam logic [N-1:0] c_TWO       = N'(2);
    localparam logic [N-1:0] c_M_DEFAULT = N'(M_DEFAULT);

    logic [N-1:0] r_q;
    logic [N-1:0] r_m;
    logic         r_rco;
    logic         r_erro;

    logic [N-1:0] w_m_menos1;
    logic         w_no_topo;
    logic         w_no_zero;

`ifndef CONTADOR_CARGA_EN
    // Load inputs remain in the port list for drop-in compatibility but have no effect.
    logic w_unused_carga;
    assign w_unused_carga = &{1'b0, carrega, D};
`endif

    // Shared compare terms for terminal count in either direction.
    always_comb begin
        w_m_menos1 = r_m - c_ONE;
        w_no_topo  = (r_q == w_m_menos1);
        w_no_zero  = (r_q == c_ZERO);
    end

    // Count, modulus and pulse registers; priority zera_s > define_m > carrega > conta.
    always_ff @(posedge clock) begin
        if (zera_s) begin
            r_q    <= c_ZERO;
            r_m    <= c_M_DEFAULT;
            r_rco  <= 1'b0;
            r_erro <= 1'b0;
        end else begin
            r_rco  <= 1'b0;
            r_erro <= 1'b0;
            if (define_m) begin
                // A modulus below 2 cannot hold a counting sequence; reject it.
                if (novo_m >= c_TWO) begin
                    r_m <= novo_m;
                    r_q <= c_ZERO;
                end else begin
                    r_erro <= 1'b1;
                end
            end
`ifdef CONTADOR_CARGA_EN
            else if (carrega) begin
                // Clamp so the count never reaches or exceeds the modulus.
                r_q <= (D < r_m) ? D : w_m_menos1;
            end
`endif
            else if (conta) begin
                if (!desce) begin
                    if (w_no_topo) begin
                        r_q   <= c_ZERO;
                        r_rco <= 1'b1;
                    end else begin
                        r_q <= r_q + c_ONE;
                    end
                end else begin
                    if (w_no_zero) begin
                        r_q   <= w_m_menos1;
                        r_rco <= 1'b1;
                    end else begin
                        r_q <= r_q - c_ONE;
                    end
                end
            end
        end
    end

    // Output mapping; fim and meio track Q, M and desce with no latency.
    always_comb begin
        Q       = r_q;
        m_atual = r_m;
        rco     = r_rco;
        erro    = r_erro;
        fim     = desce ? w_no_zero : w_no_topo;
        meio    = (r_q == (r_m >> 1));
    end

endmodule
`default_nettype wire

// File: tb/tb_contador_mod_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_contador_mod_prog
// Description : Self-checking bench for contador_mod_prog (N=13,
//               M_DEFAULT=5000). Long count sequences are hand-written;
//               short corner cases come from a directed vector table.
//               Expected load results depend on CONTADOR_CARGA_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_contador_mod_prog;

    localparam int N = 13;
    localparam int MD = 5000;

    logic         clk = 1'b0;
    logic         zera_s = 1'b1;
    logic         conta = 1'b0;
    logic         desce = 1'b0;
    logic         define_m = 1'b0;
    logic [N-1:0] novo_m = '0;
    logic         carrega = 1'b0;
    logic [N-1:0] d = '0;
    logic [N-1:0] q;
    logic [N-1:0] m_atual;
    logic         fim;
    logic         meio;
    logic         rco;
    logic         erro;

    int n_checks = 0;
    int n_errors = 0;

    contador_mod_prog #(.N(N), .M_DEFAULT(MD)) dut (
        .clock    (clk),
        .zera_s   (zera_s),
        .conta    (conta),
        .desce    (desce),
        .define_m (define_m),
        .novo_m   (novo_m),
        .carrega  (carrega),
        .D        (d),
        .Q        (q),
        .m_atual  (m_atual),
        .fim      (fim),
        .meio     (meio),
        .rco      (rco),
        .erro     (erro)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic     zera;
        logic     cnt;
        logic     dsc;
        logic     defm;
        int       novo;
        logic     carr;
        int       dval;
        int       eq;
        int       em;
        logic     efim;
        logic     emeio;
        logic     erco;
        logic     eerro;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        zera_s = 1'b0; conta = 1'b0; define_m = 1'b0; carrega = 1'b0;
        novo_m = '0; d = '0;
    endtask

    function automatic void add(input logic zera, input logic cnt, input logic dsc,
                                input logic defm, input int novo, input logic carr,
                                input int dval, input int eq, input int em,
                                input logic efim, input logic emeio,
                                input logic erco, input logic eerro);
        vec_t v;
        v.zera = zera; v.cnt = cnt; v.dsc = dsc; v.defm = defm; v.novo = novo;
        v.carr = carr; v.dval = dval; v.eq = eq; v.em = em; v.efim = efim;
        v.emeio = emeio; v.erco = erco; v.eerro = eerro;
        vecs.push_back(v);
    endfunction

    initial begin
        // Table continues from state Q=0, M=10, desce=0.
        //   zera cnt dsc defm novo carr d  | Q  M    fim meio rco erro
        add(0, 1, 0, 0, 0, 0, 0,   1, 10, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0,   2, 10, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0,   3, 10, 0, 0, 0, 0);
        add(0, 1, 0, 1, 1, 0, 0,   3, 10, 0, 0, 0, 1);   // invalid modulus 1
        add(0, 0, 0, 0, 0, 0, 0,   3, 10, 0, 0, 0, 0);   // erro lasts one cycle
        add(0, 0, 0, 1, 0, 0, 0,   3, 10, 0, 0, 0, 1);   // invalid modulus 0
`ifdef CONTADOR_CARGA_EN
        add(0, 0, 0, 0, 0, 1, 7,   7, 10, 0, 0, 0, 0);   // load
        add(0, 0, 0, 0, 0, 1, 12,  9, 10, 1, 0, 0, 0);   // load clamp
        add(0, 1, 1, 0, 0, 0, 0,   8, 10, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 1, 0,   0, 10, 1, 0, 0, 0);   // load beats conta
        add(0, 1, 1, 0, 0, 0, 0,   9, 10, 0, 0, 1, 0);   // down wrap
        add(0, 1, 0, 0, 0, 0, 0,   0, 10, 0, 0, 1, 0);   // up wrap
`else
        add(0, 0, 0, 0, 0, 1, 7,   3, 10, 0, 0, 0, 0);   // load ignored
        add(0, 0, 0, 0, 0, 1, 12,  3, 10, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0,   2, 10, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 1, 0,   1, 10, 0, 0, 0, 0);   // conta acts
        add(0, 1, 1, 0, 0, 0, 0,   0, 10, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0,   1, 10, 0, 0, 0, 0);
`endif
        add(0, 1, 0, 1, 2, 1, 1,   0, 2,  0, 0, 0, 0);   // define_m beats all
        add(0, 1, 0, 0, 0, 0, 0,   1, 2,  1, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0,   0, 2,  0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0,   0, MD, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0,   1, MD, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0,   2, MD, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0,   3, MD, 0, 0, 0, 0);
        add(1, 1, 0, 1, 10, 1, 7,  0, MD, 0, 0, 0, 0);   // reset beats all
        add(1, 1, 0, 1, 1, 0, 0,   0, MD, 0, 0, 0, 0);   // reset held

        // Reset state.
        tick();
        chk("rst_q", q, 0);
        chk("rst_m", m_atual, MD);
        chk("rst_fim", fim, 0);
        chk("rst_meio", meio, 0);
        chk("rst_rco", rco, 0);
        chk("rst_erro", erro, 0);

        // Full up-count cycle through the wrap.
        idle_inputs();
        conta = 1'b1;
        for (int i = 1; i <= MD; i++) begin
            tick();
            chk("up_q", q, i % MD);
            chk("up_rco", rco, (i == MD) ? 1 : 0);
            chk("up_meio", meio, ((i % MD) == MD / 2) ? 1 : 0);
            chk("up_fim", fim, ((i % MD) == MD - 1) ? 1 : 0);
        end
        tick();
        chk("up_after_q", q, 1);
        chk("up_after_rco", rco, 0);

        // Down count from reset.
        zera_s = 1'b1; conta = 1'b0; desce = 1'b1;
        tick();
        zera_s = 1'b0;
        #1;
        chk("dn_fim0", fim, 1);
        chk("dn_q0", q, 0);
        conta = 1'b1;
        tick();
        chk("dn_q1", q, MD - 1);
        chk("dn_rco1", rco, 1);
        chk("dn_fim1", fim, 0);
        tick();
        chk("dn_q2", q, MD - 2);
        chk("dn_rco2", rco, 0);
        tick();
        chk("dn_q3", q, MD - 3);
        desce = 1'b0;
        #1;
        chk("dn_dir_fim", fim, 0);

        // Modulus change at Q=37.
        zera_s = 1'b1; conta = 1'b0;
        tick();
        zera_s = 1'b0; conta = 1'b1;
        for (int i = 0; i < 37; i++) tick();
        chk("mc_q37", q, 37);
        define_m = 1'b1; novo_m = 13'd10;
        tick();
        define_m = 1'b0; novo_m = '0;
        chk("mc_m", m_atual, 10);
        chk("mc_q", q, 0);
        chk("mc_erro", erro, 0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("mc_cnt_q", q, i % 10);
            chk("mc_cnt_meio", meio, ((i % 10) == 5) ? 1 : 0);
            chk("mc_cnt_rco", rco, (i == 10) ? 1 : 0);
        end
        conta = 1'b0;

        // Directed vector table.
        for (int i = 0; i < vecs.size(); i++) begin
            zera_s   = vecs[i].zera;
            conta    = vecs[i].cnt;
            desce    = vecs[i].dsc;
            define_m = vecs[i].defm;
            novo_m   = N'(vecs[i].novo);
            carrega  = vecs[i].carr;
            d        = N'(vecs[i].dval);
            tick();
            chk($sformatf("v%0d_q", i), q, vecs[i].eq);
            chk($sformatf("v%0d_m", i), m_atual, vecs[i].em);
            chk($sformatf("v%0d_fim", i), fim, vecs[i].efim);
            chk($sformatf("v%0d_meio", i), meio, vecs[i].emeio);
            chk($sformatf("v%0d_rco", i), rco, vecs[i].erco);
            chk($sformatf("v%0d_erro", i), erro, vecs[i].eerro);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
